fifo_wr_arbiter: RTL and testbench

- Shares the single write port of the generator FIFO among NUM_SRC data generators.
- Each generator presents a request and a data word. The arbiter grants one source per cycle, with round-robin fairness and bounded burst locking, and never grants while the FIFO reports full.
- The winning word is registered onto the FIFO write interface.
- Sits between the generator instances and the FIFO.

---
 rtl/fifo_wr_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Shares the single write port of the generator FIFO among
//               NUM_SRC data generators. Round-robin selection with bounded
//               burst locking; no grant while the FIFO reports almost-full.
//               The winning word is registered onto the FIFO write interface.
// Ports       : clk        - clock
//               rst_n      - asynchronous active-low reset
//               req_i      - per-source write request
//               data_i     - source k data at [k*DATA_WIDTH +: DATA_WIDTH]
//               full_i     - FIFO almost-full (asserts with <= 1 free entry)
//               gnt_o      - combinational one-hot (or zero) grant
//               wr_en_o    - registered FIFO write enable
//               wr_data_o  - registered FIFO write data
//               wr_src_o   - index of the source that produced wr_data_o
//               wr_count_o - total beats written, wraps modulo 2^32
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_SRC-1:0]               req_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    data_i,
    input  logic                             full_i,
    output logic [NUM_SRC-1:0]               gnt_o,
    output logic                             wr_en_o,
    output logic [DATA_WIDTH-1:0]            wr_data_o,
    output logic [$clog2(NUM_SRC)-1:0]       wr_src_o,
    output logic [31:0]                      wr_count_o
);

    localparam int                    c_SRC_W     = $clog2(NUM_SRC);
    localparam int                    c_CNT_W     = 8;
    localparam logic [c_CNT_W-1:0]    c_MAX_BURST = c_CNT_W'(MAX_BURST);
    localparam logic [c_SRC_W-1:0]    c_LAST_SRC  = c_SRC_W'(NUM_SRC - 1);
    localparam logic [c_SRC_W:0]      c_NUM_SRC_X = (c_SRC_W + 1)'(NUM_SRC);

    localparam logic [0:0]            c_ST_IDLE   = 1'b0;
    localparam logic [0:0]            c_ST_LOCKED = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]            r_state;
    logic [c_SRC_W-1:0]    r_owner;
    logic [c_CNT_W-1:0]    r_beat_cnt;
    logic [c_SRC_W-1:0]    r_rr_ptr;

    logic [0:0]            w_nxt_state;
    logic [c_SRC_W-1:0]    w_nxt_owner;
    logic [c_CNT_W-1:0]    w_nxt_beat_cnt;
    logic [c_SRC_W-1:0]    w_nxt_rr_ptr;

    logic                  w_locked;
    logic                  w_hold;
    logic                  w_release;
    logic [c_SRC_W-1:0]    w_base;
    logic [c_SRC_W:0]      w_sum;
    logic [c_SRC_W-1:0]    w_cand;
    logic                  w_rr_found;
    logic [c_SRC_W-1:0]    w_rr_idx;
    logic                  w_gnt_valid;
    logic [c_SRC_W-1:0]    w_gnt_idx;
    logic [c_CNT_W-1:0]    w_new_cnt;

    logic                  r_wr_en;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [c_SRC_W-1:0]    r_wr_src;
    logic [31:0]           r_wr_count;

    function automatic logic [c_SRC_W-1:0] f_next_src(input logic [c_SRC_W-1:0] idx);
        return (idx == c_LAST_SRC) ? '0 : idx + 1'b1;
    endfunction

    // ------------------------------------------------------------------------
    // Grant selection and next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_locked       = (r_state == c_ST_LOCKED);
        w_hold         = w_locked && req_i[r_owner] && (r_beat_cnt < c_MAX_BURST);
        w_release      = w_locked && !req_i[r_owner];
        // When the owner drops its request the search already starts past it,
        // so the next requester is served in the same cycle (no bubble).
        w_base         = w_release ? f_next_src(r_owner) : r_rr_ptr;

        w_sum          = '0;
        w_cand         = '0;
        w_rr_found     = 1'b0;
        w_rr_idx       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_sum = {1'b0, w_base} + (c_SRC_W + 1)'(i);
            if (w_sum >= c_NUM_SRC_X) begin
                w_sum = w_sum - c_NUM_SRC_X;
            end
            w_cand = w_sum[c_SRC_W-1:0];
            if (!w_rr_found && req_i[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end

        w_gnt_valid    = 1'b0;
        w_gnt_idx      = '0;
        if (!full_i) begin
            if (w_hold) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = r_owner;
            end else if (w_rr_found) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = w_rr_idx;
            end
        end

        gnt_o          = '0;
        if (w_gnt_valid && rst_n) begin
            gnt_o[w_gnt_idx] = 1'b1;
        end

        w_nxt_state    = r_state;
        w_nxt_owner    = r_owner;
        w_nxt_beat_cnt = r_beat_cnt;
        w_nxt_rr_ptr   = r_rr_ptr;
        w_new_cnt      = '0;

        // A full stall freezes everything, so only act when not full.
        if (!full_i) begin
            if (w_gnt_valid) begin
                w_new_cnt   = (w_locked && (w_gnt_idx == r_owner)) ?
                              r_beat_cnt + 1'b1 : c_CNT_W'(1);
                w_nxt_owner = w_gnt_idx;
                if (w_new_cnt == c_MAX_BURST) begin
                    w_nxt_state    = c_ST_IDLE;
                    w_nxt_beat_cnt = '0;
                    w_nxt_rr_ptr   = f_next_src(w_gnt_idx);
                end else begin
                    w_nxt_state    = c_ST_LOCKED;
                    w_nxt_beat_cnt = w_new_cnt;
                    w_nxt_rr_ptr   = w_release ? f_next_src(r_owner) : r_rr_ptr;
                end
            end else if (w_release) begin
                w_nxt_state    = c_ST_IDLE;
                w_nxt_beat_cnt = '0;
                w_nxt_rr_ptr   = f_next_src(r_owner);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_owner    <= '0;
            r_beat_cnt <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_owner    <= w_nxt_owner;
            r_beat_cnt <= w_nxt_beat_cnt;
            r_rr_ptr   <= w_nxt_rr_ptr;
        end
    end

    // ------------------------------------------------------------------------
    // Registered write path (1-cycle latency from grant)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_wr_src   <= '0;
            r_wr_count <= '0;
        end else begin
            r_wr_en <= w_gnt_valid;
            if (w_gnt_valid) begin
                r_wr_data  <= data_i[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                r_wr_src   <= w_gnt_idx;
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    assign wr_en_o    = r_wr_en;
    assign wr_data_o  = r_wr_data;
    assign wr_src_o   = r_wr_src;
    assign wr_count_o = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter (4 sources, bursts
//               of 4, 8-bit data). Directed vector table plus hand-written
//               reset-mid-burst and counter-wrap sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NS = 4;

    logic              clk;
    logic              rst_n;
    logic [NS-1:0]     req_i;
    logic [NS*DW-1:0]  data_i;
    logic              full_i;
    logic [NS-1:0]     gnt_o;
    logic              wr_en_o;
    logic [DW-1:0]     wr_data_o;
    logic [1:0]        wr_src_o;
    logic [31:0]       wr_count_o;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .data_i     (data_i),
        .full_i     (full_i),
        .gnt_o      (gnt_o),
        .wr_en_o    (wr_en_o),
        .wr_data_o  (wr_data_o),
        .wr_src_o   (wr_src_o),
        .wr_count_o (wr_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-source data: src k starts at 8'h10+k and advances on each transfer.
    logic [DW-1:0] src_val [NS];
    always_comb begin
        data_i = '0;
        for (int k = 0; k < NS; k++) begin
            data_i[k*DW +: DW] = src_val[k];
        end
    end

    int          checks;
    int          failures;
    logic [31:0] exp_count;

    typedef struct {
        logic [3:0] req;
        logic       full;
        logic [3:0] gnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic [3:0] r, input logic f, input logic [3:0] g);
        vec_t v;
        v.req  = r;
        v.full = f;
        v.gnt  = g;
        vecs.push_back(v);
    endfunction

    // Apply one cycle of inputs, check the combinational grant, then check the
    // registered write just after the following rising edge.
    task automatic step(input logic [3:0] r, input logic f, input logic [3:0] g, input string tag);
        int          k;
        logic [7:0]  exp_data;
        k        = 0;
        exp_data = '0;
        req_i    = r;
        full_i   = f;
        #1;
        chk({tag, " gnt"}, 32'(gnt_o), 32'(g));
        for (int i = 0; i < NS; i++) begin
            if (g[i]) k = i;
        end
        if (g != 4'b0000) exp_data = src_val[k];
        @(posedge clk);
        #1;
        chk({tag, " wr_en"}, 32'(wr_en_o), 32'(g != 4'b0000));
        if (g != 4'b0000) begin
            exp_count = exp_count + 32'd1;
            chk({tag, " wr_data"}, 32'(wr_data_o), 32'(exp_data));
            chk({tag, " wr_src"}, 32'(wr_src_o), k);
            src_val[k] = src_val[k] + 8'd1;
        end
        chk({tag, " wr_count"}, wr_count_o, exp_count);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        exp_count = 32'd0;
        for (int k = 0; k < NS; k++) src_val[k] = 8'h10 + 8'(k);
        rst_n  = 1'b0;
        req_i  = 4'b1111;
        full_i = 1'b0;

        // Round-robin with bursts of 4
        add(4'b1111, 0, 4'b0001); add(4'b1111, 0, 4'b0001);
        add(4'b1111, 0, 4'b0001); add(4'b1111, 0, 4'b0001);
        add(4'b1111, 0, 4'b0010); add(4'b1111, 0, 4'b0010);
        add(4'b1111, 0, 4'b0010); add(4'b1111, 0, 4'b0010);
        add(4'b1111, 0, 4'b0100); add(4'b1111, 0, 4'b0100);
        add(4'b1111, 0, 4'b0100); add(4'b1111, 0, 4'b0100);
        add(4'b1111, 0, 4'b1000); add(4'b1111, 0, 4'b1000);
        add(4'b1111, 0, 4'b1000); add(4'b1111, 0, 4'b1000);
        add(4'b1111, 0, 4'b0001);
        add(4'b0000, 0, 4'b0000);
        // Early release: src1 two beats, then src3 with no bubble
        add(4'b0010, 0, 4'b0010); add(4'b0010, 0, 4'b0010);
        add(4'b1000, 0, 4'b1000); add(4'b1000, 0, 4'b1000);
        add(4'b1000, 0, 4'b1000); add(4'b1000, 0, 4'b1000);
        add(4'b0000, 0, 4'b0000);
        // Release searches from owner+1: src2 beats src0
        add(4'b0010, 0, 4'b0010); add(4'b0101, 0, 4'b0100);
        add(4'b0000, 0, 4'b0000);
        // Full stall mid-burst of src0, then exactly 2 more beats, then src1
        add(4'b0011, 0, 4'b0001); add(4'b0011, 0, 4'b0001);
        add(4'b0011, 1, 4'b0000); add(4'b0011, 1, 4'b0000);
        add(4'b0011, 1, 4'b0000);
        add(4'b0011, 0, 4'b0001); add(4'b0011, 0, 4'b0001);
        add(4'b0011, 0, 4'b0010);
        add(4'b0000, 0, 4'b0000);
        // Lock src2 for two beats ahead of the reset sequence
        add(4'b0100, 0, 4'b0100); add(4'b0100, 0, 4'b0100);

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset gnt", 32'(gnt_o), 32'd0);
        chk("reset wr_en", 32'(wr_en_o), 32'd0);
        chk("reset wr_data", 32'(wr_data_o), 32'd0);
        chk("reset wr_src", 32'(wr_src_o), 32'd0);
        chk("reset wr_count", wr_count_o, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].full, vecs[i].gnt, $sformatf("vec%0d", i));
        end

        // Reset mid-burst (src2 locked, beat_cnt=2): outputs clear at once
        req_i = 4'b0101;
        rst_n = 1'b0;
        #2;
        chk("midrst gnt", 32'(gnt_o), 32'd0);
        chk("midrst wr_en", 32'(wr_en_o), 32'd0);
        chk("midrst wr_data", 32'(wr_data_o), 32'd0);
        chk("midrst wr_src", 32'(wr_src_o), 32'd0);
        chk("midrst wr_count", wr_count_o, 32'd0);
        exp_count = 32'd0;
        #1;
        rst_n = 1'b1;
        // Burst abandoned and rr_ptr back at 0: src0 wins over src2
        step(4'b0101, 0, 4'b0001, "postrst");

        // Counter wrap
        force dut.r_wr_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_wr_count;
        exp_count = 32'hFFFF_FFFF;
        step(4'b0001, 0, 4'b0001, "wrap");
        chk("wrap zero", wr_count_o, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
